pc_redirect_unit: RTL

Program-counter register and control-hazard redirect logic for the RV32IM pipeline. Consumes the taken/not-taken decision from the EX-stage branch/jump detector together with the ALU-computed target. Produces the fetch PC and the flush controls for the IF/ID and ID/EX pipeline registers. Holds a redirect that resolves during a pipeline stall and applies it exactly once when the stall releases.

---
 rtl/pc_redirect_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with EX-stage redirect handling. A redirect that resolves
// during a stall is parked and applied exactly once when the stall releases.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pc_sel_i,
  input  logic [31:0] branch_target_i,
  input  logic        ex_valid_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        redirect_pending_o,
  output logic [15:0] taken_count_o
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic        take;
  logic        flush;
  logic [31:0] aligned_target;
  logic [31:0] pc_plus4;
  logic [1:0]  unused_tgt_bits;

  assign take            = ex_valid_i & pc_sel_i;
  assign aligned_target  = {branch_target_i[31:2], 2'b00};
  assign unused_tgt_bits = branch_target_i[1:0];
  assign pc_plus4        = pc_q + 32'd4;

  // In PEND the frozen EX instruction already redirected once, so the live
  // PC_SEL/BRANCH_TARGET are deliberately ignored until the stall releases.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    taken_count_d = taken_count_q;
    flush         = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!stall_i) begin
          if (take) begin
            pc_d          = aligned_target;
            flush         = 1'b1;
            taken_count_d = taken_count_q + 16'd1;
          end else begin
            pc_d = pc_plus4;
          end
        end else if (take) begin
          pend_target_d = aligned_target;
          state_d       = PEND;
        end
      end
      PEND: begin
        if (!stall_i) begin
          pc_d          = pend_target_q;
          flush         = 1'b1;
          taken_count_d = taken_count_q + 16'd1;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0000_0000;
      taken_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      taken_count_q <= taken_count_d;
    end
  end

  // Flushes are gated by reset so a live take during reset cannot leak out.
  assign flush_if_id_o      = flush & rst_ni;
  assign flush_id_ex_o      = flush & rst_ni;
  assign pc_o               = pc_q;
  assign pc_plus4_o         = pc_plus4;
  assign redirect_pending_o = (state_q == PEND);
  assign taken_count_o      = taken_count_q;

endmodule
